// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter stage: PC width, reset/step
// defaults and the run/stall state encoding.
package pc_unit_pkg;

   localparam int                PC_W         = 32;
   localparam logic [PC_W-1:0]   RESET_PC_DEF = 32'h0000_0000;
   localparam int                PC_STEP_DEF  = 4;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } pc_state_t;

endpackage

// File: rtl/pc_target_adder.sv
// Next-PC candidate generator: sequential PC + step and the branch/jump
// target formed from the sign-extended word offset scaled to bytes.
module pc_target_adder
   import pc_unit_pkg::*;
#(
   parameter int PC_STEP  = PC_STEP_DEF,
   parameter int OFFSET_W = 8
) (
   input  logic [PC_W-1:0]            pc,
   input  logic signed [OFFSET_W-1:0] offset,
   output logic [PC_W-1:0]            pc_plus4,
   output logic [PC_W-1:0]            target
);

   logic signed [PC_W-1:0] offset_ext;
   logic signed [PC_W-1:0] offset_bytes;

   // Sign-extend the word offset from its top bit to the full PC width.
   function automatic logic signed [PC_W-1:0] sext_offset(input logic signed [OFFSET_W-1:0] v);
      return {{(PC_W-OFFSET_W){v[OFFSET_W-1]}}, v};
   endfunction

   // Word offset to byte offset; both sums wrap silently modulo 2^32.
   always_comb begin
      offset_ext   = sext_offset(offset);
      offset_bytes = offset_ext <<< 2;
      pc_plus4     = pc + PC_W'(PC_STEP);
      target       = pc_plus4 + $unsigned(offset_bytes);
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: holds the PC, generates the next-PC candidates and
// the next-PC mux select, and stalls on memory busy-wait.
// Optional feature macro: PC_PERF_CNT_EN adds INSTR_COUNT / TAKEN_COUNT.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              PC_STEP  = PC_STEP_DEF,
   parameter int              OFFSET_W = 8
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       BUSYWAIT,
   input  logic                       JUMP,
   input  logic                       BRANCH_EQ,
   input  logic                       BRANCH_NE,
   input  logic                       ZERO,
   input  logic signed [OFFSET_W-1:0] OFFSET,
   input  logic [PC_W-1:0]            NEXT_PC,
   output logic [PC_W-1:0]            PC,
   output logic [PC_W-1:0]            PC_PLUS4,
   output logic [PC_W-1:0]            TARGET,
   output logic                       PC_SEL,
   output logic                       STALLED
`ifdef PC_PERF_CNT_EN
   ,
   output logic [PC_W-1:0]            INSTR_COUNT,
   output logic [PC_W-1:0]            TAKEN_COUNT
`endif
);

   pc_state_t state_q;
   pc_state_t state_d;
   logic      pc_update;

   pc_target_adder #(
      .PC_STEP  (PC_STEP),
      .OFFSET_W (OFFSET_W)
   ) u_adder (
      .pc       (PC),
      .offset   (OFFSET),
      .pc_plus4 (PC_PLUS4),
      .target   (TARGET)
   );

   // JUMP or either satisfied branch picks the target; both branch enables
   // together always resolve to taken since ZERO satisfies one of them.
   assign PC_SEL    = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
   assign pc_update = ~BUSYWAIT;
   assign STALLED   = (state_q == ST_STALL);

   // Run/stall state register; reset forces RUN even during a stall.
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // Next-state logic: BUSYWAIT sampled at an edge decides stall or run.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (BUSYWAIT)  state_d = ST_STALL;
         ST_STALL: if (!BUSYWAIT) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // PC register: loads the externally selected next PC on unstalled edges.
   always_ff @(posedge CLK) begin
      if (RESET)          PC <= RESET_PC;
      else if (pc_update) PC <= NEXT_PC;
   end

`ifdef PC_PERF_CNT_EN
   // Performance counters: retired updates and taken redirects, wrapping.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         INSTR_COUNT <= '0;
         TAKEN_COUNT <= '0;
      end else if (pc_update) begin
         INSTR_COUNT <= INSTR_COUNT + 1'b1;
         if (PC_SEL) TAKEN_COUNT <= TAKEN_COUNT + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus rows push hand-computed expected
// outputs, a negedge monitor pops and compares them.
module tb_pc_unit;

   logic        CLK = 1'b0;
   logic        RESET, BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO;
   logic [7:0]  OFFSET;
   logic [31:0] NEXT_PC, PC, PC_PLUS4, TARGET;
   logic        PC_SEL, STALLED;
   logic        ovr_en;
   logic [31:0] ovr_val;
`ifdef PC_PERF_CNT_EN
   logic [31:0] INSTR_COUNT, TAKEN_COUNT;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] p4;
      logic [31:0] tgt;
      logic        sel;
      logic        stl;
   } exp_t;

   exp_t sb[$];

   always #5 CLK = ~CLK;

   // External next-PC mux, with an override to reach arbitrary PCs.
   assign NEXT_PC = ovr_en ? ovr_val : (PC_SEL ? TARGET : PC_PLUS4);

   pc_unit dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .BUSYWAIT    (BUSYWAIT),
      .JUMP        (JUMP),
      .BRANCH_EQ   (BRANCH_EQ),
      .BRANCH_NE   (BRANCH_NE),
      .ZERO        (ZERO),
      .OFFSET      (OFFSET),
      .NEXT_PC     (NEXT_PC),
      .PC          (PC),
      .PC_PLUS4    (PC_PLUS4),
      .TARGET      (TARGET),
      .PC_SEL      (PC_SEL),
      .STALLED     (STALLED)
`ifdef PC_PERF_CNT_EN
      ,
      .INSTR_COUNT (INSTR_COUNT),
      .TAKEN_COUNT (TAKEN_COUNT)
`endif
   );

   // Monitor: compare the DUT against the oldest expectation each negedge.
   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         if (PC !== e.pc || PC_PLUS4 !== e.p4 || TARGET !== e.tgt ||
             PC_SEL !== e.sel || STALLED !== e.stl) begin
            n_bad++;
            $display("FAIL %s: got pc=%h p4=%h tgt=%h sel=%b stl=%b want pc=%h p4=%h tgt=%h sel=%b stl=%b",
                     e.name, PC, PC_PLUS4, TARGET, PC_SEL, STALLED,
                     e.pc, e.p4, e.tgt, e.sel, e.stl);
         end
      end
   end

   // One clock row: drive inputs, queue expectation for this cycle, take the edge.
   task automatic row(input string nm, input logic rst, input logic bw,
                      input logic j, input logic beq, input logic bne, input logic z,
                      input logic [7:0] off, input logic oe, input logic [31:0] ov,
                      input logic [31:0] e_pc, input logic [31:0] e_p4,
                      input logic [31:0] e_tgt, input logic e_sel, input logic e_stl);
      exp_t e;
      RESET = rst; BUSYWAIT = bw; JUMP = j; BRANCH_EQ = beq; BRANCH_NE = bne;
      ZERO = z; OFFSET = off; ovr_en = oe; ovr_val = ov;
      e.name = nm; e.pc = e_pc; e.p4 = e_p4; e.tgt = e_tgt; e.sel = e_sel; e.stl = e_stl;
      sb.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1; BUSYWAIT = 1'b0; JUMP = 1'b0; BRANCH_EQ = 1'b0; BRANCH_NE = 1'b0;
      ZERO = 1'b0; OFFSET = 8'h00; ovr_en = 1'b0; ovr_val = 32'h0;
      @(posedge CLK);
      #1;
      //   name         rst bw j beq bne z  off    oe ovr   pc           p4           tgt          sel stl
      row("reset_hold", 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h00,       32'h04,       32'h04,       0, 0);
      row("run_0",      0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h00,       32'h04,       32'h04,       0, 0);
      row("run_4",      0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h04,       32'h08,       32'h08,       0, 0);
      row("run_8",      0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h08,       32'h0C,       32'h0C,       0, 0);
      row("run_c",      0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0C,       32'h10,       32'h10,       0, 0);
      row("beq_taken",  0, 0, 0, 1, 0, 1, 8'h03, 0, 0, 32'h10,       32'h14,       32'h20,       1, 0);
      row("jmp_back",   0, 0, 1, 0, 0, 0, 8'hFB, 0, 0, 32'h20,       32'h24,       32'h10,       1, 0);
      row("beq_not",    0, 0, 0, 1, 0, 0, 8'h03, 0, 0, 32'h10,       32'h14,       32'h20,       0, 0);
      row("jmp_fe_14",  0, 0, 1, 0, 0, 0, 8'hFE, 0, 0, 32'h14,       32'h18,       32'h10,       1, 0);
      row("jmp_dom",    0, 0, 1, 0, 1, 1, 8'hFE, 0, 0, 32'h10,       32'h14,       32'h0C,       1, 0);
      row("beq_and_bne",0, 0, 0, 1, 1, 0, 8'h01, 0, 0, 32'h0C,       32'h10,       32'h14,       1, 0);
      row("jmp_to_8",   0, 0, 1, 0, 0, 0, 8'hFC, 0, 0, 32'h14,       32'h18,       32'h08,       1, 0);
      row("stall_1",    0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 32'h08,       32'h0C,       32'h0C,       0, 0);
      row("stall_2",    0, 1, 1, 0, 0, 0, 8'h10, 0, 0, 32'h08,       32'h0C,       32'h4C,       1, 1);
      row("stall_3",    0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 32'h08,       32'h0C,       32'h0C,       0, 1);
      row("release",    0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h08,       32'h0C,       32'h0C,       0, 1);
      row("after_rel",  0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h0C,       32'h10,       32'h10,       0, 0);
      row("jmp_to_40",  0, 0, 1, 0, 0, 0, 8'h0B, 0, 0, 32'h10,       32'h14,       32'h40,       1, 0);
      row("stall_40",   0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 32'h40,       32'h44,       32'h44,       0, 0);
      row("rst_mid",    1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 32'h40,       32'h44,       32'h44,       0, 1);
      row("post_rst",   0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 32'h00,       32'h04,       32'h04,       0, 0);
      row("post_rst2",  0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h00,       32'h04,       32'h04,       0, 1);
      row("off_ff",     0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 32'h04,       32'h08,       32'h04,       0, 0);
      row("override",   0, 0, 0, 0, 0, 0, 8'h00, 1, 32'hFFFF_FFFC, 32'h08, 32'h0C,   32'h0C,       0, 0);
      row("wrap_p4",    0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'hFFFF_FFFC, 32'h00,       32'h00,       0, 0);
      row("wrap_tgt",   0, 0, 0, 0, 0, 0, 8'hFE, 0, 0, 32'h00,       32'h04,       32'hFFFF_FFFC, 0, 0);
`ifdef PC_PERF_CNT_EN
      row("perf_rst",   1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h04,       32'h08,       32'h08,       0, 0);
      row("perf_jmp",   0, 0, 1, 0, 0, 0, 8'h01, 0, 0, 32'h00,       32'h04,       32'h08,       1, 0);
      row("perf_seq",   0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h08,       32'h0C,       32'h0C,       0, 0);
      row("perf_bne",   0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 32'h0C,       32'h10,       32'h10,       1, 0);
      row("perf_stall", 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 32'h10,       32'h14,       32'h14,       0, 0);
      row("perf_rel",   0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h10,       32'h14,       32'h14,       0, 1);
      row("perf_seq2",  0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h14,       32'h18,       32'h18,       0, 0);
      n_cmp++;
      if (INSTR_COUNT !== 32'd5) begin
         n_bad++;
         $display("FAIL instr_count: got %0d want 5", INSTR_COUNT);
      end
      n_cmp++;
      if (TAKEN_COUNT !== 32'd2) begin
         n_bad++;
         $display("FAIL taken_count: got %0d want 2", TAKEN_COUNT);
      end
`endif
      BUSYWAIT = 1'b1;
      for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge CLK);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
